// File: rtl/elevator_controller.sv
// SCAN-style car controller: consumes latched in-car and hall-call vectors,
// moves the car floor by floor, opens the door and pulses clears for served calls.
module elevator_controller #(
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req_in,
    input  logic [9:0] req_out,
    output logic [2:0] floor,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic [5:0] clr_in,
    output logic [9:0] clr_out
);

    // Request handshake: a request bit stays high until this block returns a
    // one-cycle clr pulse for it; the upstream latch drops the bit on the edge
    // that ends the pulse, so bits whose clr is high count as already served.

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

    state_t     state, state_n;
    dir_t       dir, dir_n;
    logic [2:0] floor_n, nxt;
    logic [7:0] move_cnt, move_cnt_n, door_cnt, door_cnt_n;
    logic [5:0] clr_in_n, eff_in, pend;
    logic [9:0] clr_out_n, eff_out, hall_hit, same_call;
    logic       above, below, beyond, going_up;

    function automatic logic [9:0] up_mask(input logic [2:0] f);
        logic [9:0] m;
        m = '0;
        if (f <= 3'd4) m[{1'b0, f}] = 1'b1;
        return m;
    endfunction

    function automatic logic [9:0] dn_mask(input logic [2:0] f);
        logic [9:0] m;
        m = '0;
        if (f != 3'd0 && f <= 3'd5) m[{1'b0, f} + 4'd4] = 1'b1;
        return m;
    endfunction

    function automatic logic any_above(input logic [5:0] p, input logic [2:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 6; i++) if (i > int'(f)) r = r | p[3'(i)];
        return r;
    endfunction

    function automatic logic any_below(input logic [5:0] p, input logic [2:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 6; i++) if (i < int'(f)) r = r | p[3'(i)];
        return r;
    endfunction

    assign eff_in  = req_in & ~clr_in;
    assign eff_out = req_out & ~clr_out;

    always_comb begin
        pend = '0;
        for (int f = 0; f < 6; f++)
            pend[f] = eff_in[f] | (|((up_mask(3'(f)) | dn_mask(3'(f))) & eff_out));
    end

    assign above = any_above(pend, floor);
    assign below = any_below(pend, floor);

    assign moving_up   = (state == MOVE_UP);
    assign moving_down = (state == MOVE_DOWN);
    assign door_open   = (state == DOOR_OPEN);

    always_comb begin
        state_n    = state;
        dir_n      = dir;
        floor_n    = floor;
        move_cnt_n = move_cnt;
        door_cnt_n = door_cnt;
        clr_in_n   = '0;
        clr_out_n  = '0;
        nxt        = floor;
        beyond     = 1'b0;
        going_up   = 1'b0;
        hall_hit   = '0;
        same_call  = '0;
        case (state)
            IDLE: begin
                if (pend[floor]) begin
                    state_n          = DOOR_OPEN;
                    door_cnt_n       = 8'd1;
                    clr_in_n[floor]  = eff_in[floor];
                    clr_out_n        = (up_mask(floor) | dn_mask(floor)) & eff_out;
                end else if (above) begin
                    state_n    = MOVE_UP;
                    dir_n      = DIR_UP;
                    move_cnt_n = 8'd1;
                end else if (below) begin
                    state_n    = MOVE_DOWN;
                    dir_n      = DIR_DOWN;
                    move_cnt_n = 8'd1;
                end else begin
                    dir_n = DIR_NONE;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                going_up = (state == MOVE_UP);
                if (move_cnt == 8'(MOVE_CYCLES)) begin
                    nxt        = going_up ? floor + 3'd1 : floor - 3'd1;
                    floor_n    = nxt;
                    move_cnt_n = 8'd0;
                    beyond     = going_up ? any_above(pend, nxt) : any_below(pend, nxt);
                    same_call  = (going_up ? up_mask(nxt) : dn_mask(nxt)) & eff_out;
                    if (eff_in[nxt] || (|same_call) || (!beyond && pend[nxt])) begin
                        state_n       = DOOR_OPEN;
                        door_cnt_n    = 8'd1;
                        clr_in_n[nxt] = eff_in[nxt];
                        clr_out_n     = same_call;
                        // Nothing further ahead: serve the opposite call too and turn around.
                        if (!beyond) begin
                            clr_out_n = clr_out_n |
                                ((going_up ? dn_mask(nxt) : up_mask(nxt)) & eff_out);
                            dir_n = going_up ? DIR_DOWN : DIR_UP;
                        end
                    end else if (!beyond) begin
                        state_n = IDLE;
                        dir_n   = DIR_NONE;
                    end else begin
                        move_cnt_n = 8'd1;
                    end
                end else begin
                    move_cnt_n = move_cnt + 8'd1;
                end
            end
            DOOR_OPEN: begin
                if (dir != DIR_DOWN) hall_hit = hall_hit | (up_mask(floor) & eff_out);
                if (dir != DIR_UP)   hall_hit = hall_hit | (dn_mask(floor) & eff_out);
                if (eff_in[floor] || (|hall_hit)) begin
                    door_cnt_n      = 8'd1;
                    clr_in_n[floor] = eff_in[floor];
                    clr_out_n       = hall_hit;
                end else if (door_cnt == 8'(DOOR_CYCLES)) begin
                    door_cnt_n = 8'd0;
                    move_cnt_n = 8'd1;
                    if (dir == DIR_UP && above) begin
                        state_n = MOVE_UP;
                    end else if (dir == DIR_DOWN && below) begin
                        state_n = MOVE_DOWN;
                    end else if (dir == DIR_UP && below) begin
                        state_n = MOVE_DOWN;
                        dir_n   = DIR_DOWN;
                    end else if (dir == DIR_DOWN && above) begin
                        state_n = MOVE_UP;
                        dir_n   = DIR_UP;
                    end else begin
                        state_n    = IDLE;
                        dir_n      = DIR_NONE;
                        move_cnt_n = 8'd0;
                    end
                end else begin
                    door_cnt_n = door_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            dir      <= DIR_NONE;
            floor    <= 3'd0;
            move_cnt <= 8'd0;
            door_cnt <= 8'd0;
            clr_in   <= '0;
            clr_out  <= '0;
        end else begin
            state    <= state_n;
            dir      <= dir_n;
            floor    <= floor_n;
            move_cnt <= move_cnt_n;
            door_cnt <= door_cnt_n;
            clr_in   <= clr_in_n;
            clr_out  <= clr_out_n;
        end
    end

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller: per-cycle expected outputs are queued
// with each step and compared one per clock; the bench also acts as the request latch.
module tb_elevator_controller;

    localparam int W = 22;
    localparam logic [2:0] M_IDLE = 3'b000;
    localparam logic [2:0] M_UP   = 3'b100;
    localparam logic [2:0] M_DN   = 3'b010;
    localparam logic [2:0] M_DOOR = 3'b001;

    logic       clk;
    logic       rst;
    logic [5:0] req_in;
    logic [9:0] req_out;
    logic [2:0] floor;
    logic       moving_up, moving_down, door_open;
    logic [5:0] clr_in;
    logic [9:0] clr_out;

    logic [W-1:0] exp_q[$];
    int           vectors = 0;
    int           miscompares = 0;
    string        tag = "none";

    elevator_controller #(.MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .req_out(req_out),
        .floor(floor), .moving_up(moving_up), .moving_down(moving_down),
        .door_open(door_open), .clr_in(clr_in), .clr_out(clr_out)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: one clock; the upstream latch drops bits whose clr pulse just ended.
    task automatic tick();
        logic [5:0] ci;
        logic [9:0] co;
        ci = clr_in;
        co = clr_out;
        @(posedge clk);
        #1;
        req_in  = req_in & ~ci;
        req_out = req_out & ~co;
        @(negedge clk);
    endtask

    task automatic push(input int n, input logic [2:0] f, input logic [2:0] mode,
                        input logic [5:0] ci, input logic [9:0] co);
        for (int k = 0; k < n; k++) exp_q.push_back({f, mode, ci, co});
    endtask

    // Scoreboard: one popped expectation per clock
    task automatic run();
        logic [W-1:0] obs, exp_v;
        int idx;
        idx = 0;
        while (exp_q.size() != 0) begin
            tick();
            exp_v = exp_q.pop_front();
            obs = {floor, moving_up, moving_down, door_open, clr_in, clr_out};
            vectors++;
            assert (obs === exp_v) else begin
                miscompares++;
                $error("FAIL %s[%0d] observed={f%0d u%b d%b o%b ci%b co%b} expected={f%0d u%b d%b o%b ci%b co%b}",
                       tag, idx, obs[21:19], obs[18], obs[17], obs[16], obs[15:10], obs[9:0],
                       exp_v[21:19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:10], exp_v[9:0]);
            end
            idx++;
        end
    endtask

    initial begin
        rst = 1'b0; req_in = '0; req_out = '0;
        tag = "reset"; push(2, 3'd0, M_IDLE, 6'd0, 10'd0); run();
        rst = 1'b1;
        tag = "idle"; push(1, 3'd0, M_IDLE, 6'd0, 10'd0); run();

        tag = "door_floor0"; req_in = 6'b000001;
        push(1, 3'd0, M_DOOR, 6'b000001, 10'd0); push(2, 3'd0, M_DOOR, 6'd0, 10'd0);
        push(1, 3'd0, M_IDLE, 6'd0, 10'd0); run();

        tag = "travel_to_3"; req_in[3] = 1'b1;
        push(4, 3'd0, M_UP, 6'd0, 10'd0); push(4, 3'd1, M_UP, 6'd0, 10'd0);
        push(4, 3'd2, M_UP, 6'd0, 10'd0); push(1, 3'd3, M_DOOR, 6'b001000, 10'd0);
        push(2, 3'd3, M_DOOR, 6'd0, 10'd0); push(1, 3'd3, M_IDLE, 6'd0, 10'd0); run();

        tag = "top_down_call"; req_out[9] = 1'b1;
        push(4, 3'd3, M_UP, 6'd0, 10'd0); push(4, 3'd4, M_UP, 6'd0, 10'd0);
        push(1, 3'd5, M_DOOR, 6'd0, 10'h200); push(2, 3'd5, M_DOOR, 6'd0, 10'd0);
        push(1, 3'd5, M_IDLE, 6'd0, 10'd0); run();

        tag = "reset_idle"; rst = 1'b0; push(1, 3'd0, M_IDLE, 6'd0, 10'd0); run();
        rst = 1'b1;
        tag = "mid_move"; req_in[5] = 1'b1;
        push(4, 3'd0, M_UP, 6'd0, 10'd0); push(4, 3'd1, M_UP, 6'd0, 10'd0);
        push(1, 3'd2, M_UP, 6'd0, 10'd0); run();
        tag = "mid_move_reset"; rst = 1'b0; req_in = '0;
        push(1, 3'd0, M_IDLE, 6'd0, 10'd0); run();
        rst = 1'b1; push(1, 3'd0, M_IDLE, 6'd0, 10'd0); run();

        tag = "scan_up_down"; req_in[5] = 1'b1; req_out[2] = 1'b1; req_out[6] = 1'b1;
        push(4, 3'd0, M_UP, 6'd0, 10'd0); push(4, 3'd1, M_UP, 6'd0, 10'd0);
        push(1, 3'd2, M_DOOR, 6'd0, 10'h004); push(2, 3'd2, M_DOOR, 6'd0, 10'd0);
        push(4, 3'd2, M_UP, 6'd0, 10'd0); push(4, 3'd3, M_UP, 6'd0, 10'd0);
        push(4, 3'd4, M_UP, 6'd0, 10'd0); push(1, 3'd5, M_DOOR, 6'b100000, 10'd0);
        push(2, 3'd5, M_DOOR, 6'd0, 10'd0); push(4, 3'd5, M_DN, 6'd0, 10'd0);
        push(4, 3'd4, M_DN, 6'd0, 10'd0); push(4, 3'd3, M_DN, 6'd0, 10'd0);
        push(1, 3'd2, M_DOOR, 6'd0, 10'h040); push(2, 3'd2, M_DOOR, 6'd0, 10'd0);
        push(1, 3'd2, M_IDLE, 6'd0, 10'd0); run();

        tag = "above_wins"; req_in = 6'b110001;
        push(4, 3'd2, M_UP, 6'd0, 10'd0); push(4, 3'd3, M_UP, 6'd0, 10'd0);
        push(1, 3'd4, M_DOOR, 6'b010000, 10'd0); push(1, 3'd4, M_DOOR, 6'd0, 10'd0); run();
        tag = "door_restart"; req_in[4] = 1'b1;
        push(1, 3'd4, M_DOOR, 6'b010000, 10'd0); push(2, 3'd4, M_DOOR, 6'd0, 10'd0);
        push(4, 3'd4, M_UP, 6'd0, 10'd0); push(1, 3'd5, M_DOOR, 6'b100000, 10'd0);
        push(2, 3'd5, M_DOOR, 6'd0, 10'd0);
        push(4, 3'd5, M_DN, 6'd0, 10'd0); push(4, 3'd4, M_DN, 6'd0, 10'd0);
        push(4, 3'd3, M_DN, 6'd0, 10'd0); push(4, 3'd2, M_DN, 6'd0, 10'd0);
        push(4, 3'd1, M_DN, 6'd0, 10'd0); push(1, 3'd0, M_DOOR, 6'b000001, 10'd0);
        push(2, 3'd0, M_DOOR, 6'd0, 10'd0); push(1, 3'd0, M_IDLE, 6'd0, 10'd0); run();

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
- Car-motion stage directly downstream of the request-latching input module.
- Consumes the latched in-car vector (6 floors) and hall-call vector (10 calls).
- Runs a SCAN-style state machine that moves the car, opens the door and decides stops.
- Emits one-cycle clear pulses per request bit so the upstream latch can drop served calls.

Parameters:
- MOVE_CYCLES, 4, clock cycles to travel one floor (1..255).
- DOOR_CYCLES, 3, clock cycles the door stays open (1..255).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset.
- req_in  input  6  latched in-car requests; bit f = floor f (0..5).
- req_out  input  10  latched hall calls; bits 0..4 = up call at floors 0..4; bits 5..9 = down call at floors 1..5 (bit 5+k-1 = floor k).
- floor  output  3  current floor, 0..5.
- moving_up  output  1  car travelling upward.
- moving_down  output  1  car travelling downward.
- door_open  output  1  door open.
- clr_in  output  6  one-cycle pulse per served in-car bit.
- clr_out  output  10  one-cycle pulse per served hall-call bit.

Behaviour:
- Reset (rst low at a rising edge, any state, including mid-move or door open):
  - floor=0, state IDLE, dir=NONE.
  - Move and door counters = 0.
  - All outputs 0 on the following cycle.
- Derived signals:
  - pending[f] = req_in[f] | up call at f | down call at f.
  - above = any pending[f'] for f' > floor.
  - below = any pending[f'] for f' < floor.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE:
  - pending[floor] set -> DOOR_OPEN; clear in-car and both hall calls at floor.
  - Else above -> MOVE_UP, dir=UP.
  - Else below -> MOVE_DOWN, dir=DOWN.
  - When above and below are both set, above wins.
  - Door opens on the edge after the request is visible (1-cycle latency).
- MOVE_UP / MOVE_DOWN:
  - moving_up or moving_down = 1; counter runs 1..MOVE_CYCLES.
  - On the edge the counter reaches MOVE_CYCLES: floor <= floor±1 and the counter resets.
  - On that same edge, evaluate the stop rule at the new floor n:
    - Stop if req_in[n] is set.
    - Stop if the same-direction hall call at n is set.
    - Stop if no pending request exists beyond n in the travel direction and pending[n] is set.
  - On stop: state DOOR_OPEN, door_open=1, moving flag=0, clr pulses — all on that same edge.
  - No pending requests anywhere -> IDLE.
- Clearing on a stop:
  - Always clear req_in[n] and the same-direction hall call.
  - Clear the opposite hall call at n only when nothing is pending beyond n; dir then reverses.
  - Floor 5: only the down call exists. Floor 0: only the up call exists.
  - floor never exceeds 5 or goes below 0. MOVE_UP is never entered at floor 5; MOVE_DOWN is never entered at floor 0.
- DOOR_OPEN:
  - door_open=1 for DOOR_CYCLES cycles.
  - A new req_in[floor] or a hall call at floor matching dir during DOOR_OPEN restarts the door counter and pulses the matching clr bit.
  - At expiry: continue in dir if requests exist beyond; else reverse if requests exist on the other side; else IDLE with dir=NONE.
- Output exclusivity: door_open, moving_up and moving_down are mutually exclusive every cycle.
- clr pulses: clr_in and clr_out are single-cycle and never repeat for the same service event.
- Simultaneous events: a request arriving on the same edge as a stop decision is considered in that decision.

Test Plan (MOVE_CYCLES=4, DOOR_CYCLES=3):
1. After reset, req_in=6'b000001 -> next cycle door_open=1 and clr_in=6'b000001 for 1 cycle; door_open high for 3 cycles, then IDLE with all outputs 0.
2. At floor 0 IDLE, req_in[3]=1 -> moving_up next cycle; floor steps 1, 2, 3 every 4 cycles; on the edge floor=3: door_open=1, clr_in[3] pulses.
3. req_in[5] and req_out[2] (up call at floor 2) from floor 0 -> car stops at 2 with clr_out[2] pulse; proceeds to 5; req_out[6] (down call at floor 2), if set, is not cleared at the first stop.
4. At floor 3 IDLE, only req_out[9] (down call at floor 5) -> car moves up, stops at 5, clr_out[9] pulses; floor never shows 6; car then returns to IDLE.
5. rst low for one edge while moving_up at floor 2 -> next cycle floor=0, moving_up=0, door_open=0, clr_in=0, clr_out=0.
6. During DOOR_OPEN at floor 4 (dir UP), re-press req_in[4] in the 2nd open cycle -> door counter restarts, door stays open 3 further cycles, second clr_in[4] pulse.
